button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning consecutive stable cycles required before the debounced level changes (legal range 1..65535).
REQ-002 SHALL have parameter REPEAT_DELAY, default 24'd5000000, meaning cycles from a press to the first auto-repeat press.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 24'd1000000, meaning cycles between subsequent auto-repeat presses.
REQ-004 SHALL have port clk, input, 1, the single clock; the block SHALL use one clock only.
REQ-005 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port chip_select, input, 1, active-high deselect: 1 masks all outputs, 0 enables them.
REQ-007 SHALL have port button_raw, input, 4, asynchronous raw pushbutton levels, active-high.
REQ-008 SHALL have port button_level, output, 4, debounced level per button.
REQ-009 SHALL have port button_press, output, 4, one-cycle pulse per debounced rising edge (and per auto-repeat event when enabled).
REQ-010 SHALL have port button_release, output, 4, one-cycle pulse per debounced falling edge.
REQ-011 SHALL have port any_press, output, 1, OR of button_press.

Function
REQ-012 Each button_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL hold a stability counter: it increments each cycle the synchronized input differs from the debounced level and clears to 0 on any cycle they are equal.
REQ-014 When a channel counter would reach DEBOUNCE_CYCLES, the debounced level SHALL toggle on that clock edge and the counter SHALL clear.
REQ-015 A raw transition held stable SHALL appear on button_level exactly 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples it.
REQ-016 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change and no pulse.
REQ-017 button_press[i] SHALL be registered and high for exactly the one cycle in which button_level[i] first reads 1; button_release[i] likewise when it first reads 0.
REQ-018 Channels SHALL be fully independent; simultaneous edges on several buttons SHALL produce simultaneous pulses on each.
REQ-019 While chip_select=1, all outputs SHALL read 0; internal synchronizers, counters and levels SHALL keep running.
REQ-020 On chip_select falling 1->0 with a button already debounced high, no press pulse SHALL be generated for that held button.

Reset
REQ-021 n_rst=0 SHALL asynchronously clear synchronizers, counters, levels, repeat counters and all outputs to 0.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count; after release, the debounce window restarts from 0.

Configuration
REQ-023 Macro BUTTON_AUTOREPEAT_EN SHALL, when defined, enable auto-repeat: while button_level[i]=1, a per-channel counter SHALL emit an extra button_press[i] pulse REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD cycles.
REQ-024 With BUTTON_AUTOREPEAT_EN defined, release SHALL clear the repeat counter in the same cycle; re-press SHALL restart from REPEAT_DELAY.
REQ-025 Without BUTTON_AUTOREPEAT_EN, no repeat counters SHALL be synthesized and exactly one press pulse SHALL occur per debounced rising edge.

Structure
REQ-026 A shared package guitar_villains_pkg SHALL hold NUM_BUTTONS (4), typedef btn_vec_t (logic [3:0]), and default debounce/repeat constants.
REQ-027 A sub-module btn_debounce_ch SHALL implement one channel (synchronizer, counter, level, edge pulses, optional repeat); the top SHALL instantiate it NUM_BUTTONS times and add chip_select masking and any_press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 button_raw[0] 0->1 held -> button_level[0]=1 and button_press[0] pulse exactly 6 edges later; any_press pulses with it.
REQ-029 button_raw[1] high for 3 cycles then low -> no level change, no press, no release.
REQ-030 buttons 2 and 3 rise in the same cycle -> both press pulses in the same cycle; later release both -> both release pulses 6 edges after fall.
REQ-031 chip_select=1 during a press on button 0, then 0 while still held -> outputs 0 while deselected, button_level[0]=1 after, no press pulse.
REQ-032 n_rst pulsed low after 2 of 4 stable cycles -> outputs 0 immediately; raw still high after reset release -> press 6 edges after reset deassertion.
REQ-033 With BUTTON_AUTOREPEAT_EN, hold button 0 -> press at t0, t0+10, t0+13, t0+16; release -> pulses stop, release pulse once.

Source files
------------

// File: rtl/guitar_villains_pkg.sv
// rtl/guitar_villains_pkg.sv - shared button width, vector type and default timing constants
package guitar_villains_pkg;

  localparam int unsigned NUM_BUTTONS = 4;

  typedef logic [3:0] btn_vec_t;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [23:0] DEF_REPEAT_DELAY    = 24'd5000000;
  localparam logic [23:0] DEF_REPEAT_PERIOD   = 24'd1000000;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button bus: chip select and raw levels in, conditioned levels and pulses out
interface button_conditioner_if;
  import guitar_villains_pkg::*;

  logic     chip_select;
  btn_vec_t button_raw;
  btn_vec_t button_level;
  btn_vec_t button_press;
  btn_vec_t button_release;
  logic     any_press;

  modport master (
    output chip_select,
    output button_raw,
    input  button_level,
    input  button_press,
    input  button_release,
    input  any_press
  );

  modport slave (
    input  chip_select,
    input  button_raw,
    output button_level,
    output button_press,
    output button_release,
    output any_press
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, debounce counter, level and edge pulses
// Auto-repeat press pulses are built only when BUTTON_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import guitar_villains_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;

`ifdef BUTTON_AUTOREPEAT_EN
  logic [23:0] rpt_cnt_q, rpt_cnt_d;
  logic        rpt_started_q, rpt_started_d;
`endif

  always_comb begin
    cnt_inc   = cnt_q + 16'd1;
    cnt_d     = 16'd0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Counter only runs while the synchronized input disagrees with the level.
    if (sync2_q != level_q) begin
      if (cnt_inc == DEBOUNCE_CYCLES) begin
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    rpt_cnt_d     = 24'd0;
    rpt_started_d = 1'b0;
    // The release edge wins over a coincident repeat event.
    if (level_q && !release_d) begin
      rpt_cnt_d     = rpt_cnt_q + 24'd1;
      rpt_started_d = rpt_started_q;
      if (rpt_cnt_d == (rpt_started_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
        press_d       = 1'b1;
        rpt_cnt_d     = 24'd0;
        rpt_started_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= 16'd0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rpt_cnt_q     <= 24'd0;
      rpt_started_q <= 1'b0;
    end else begin
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_started_q <= rpt_started_d;
    end
  end
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - four debounced button channels with chip-select masking and any_press
// Optional auto-repeat is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_conditioner
  import guitar_villains_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [23:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter logic [23:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                  clk,
  input logic                  n_rst,
  button_conditioner_if.slave  bus
);

  btn_vec_t ch_level, ch_press, ch_release;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .n_rst     (n_rst),
      .raw_i     (bus.button_raw[i]),
      .level_o   (ch_level[i]),
      .press_o   (ch_press[i]),
      .release_o (ch_release[i])
    );
  end

  // Masking is output-only so channels keep tracking while deselected.
  assign bus.button_level   = bus.chip_select ? '0 : ch_level;
  assign bus.button_press   = bus.chip_select ? '0 : ch_press;
  assign bus.button_release = bus.chip_select ? '0 : ch_release;
  assign bus.any_press      = |bus.button_press;

endmodule
